// File: rtl/core_seq_pkg.sv
// Shared types and constants for the attention-tile core sequencer:
// FSM state encoding, instruction-word bit positions and opcodes.
package core_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QLOAD,
        S_KLOAD,
        S_KFEED,
        S_EXEC,
        S_DRAIN,
        S_DONE,
        S_READBACK
    } state_e;

    localparam int INST_W     = 19;
    localparam int QK_W       = 4;

    localparam int I_P_WR     = 0;
    localparam int I_P_RD     = 1;
    localparam int I_K_WR     = 2;
    localparam int I_K_RD     = 3;
    localparam int I_Q_WR     = 4;
    localparam int I_Q_RD     = 5;
    localparam int I_MAC_LSB  = 6;
    localparam int I_PM_LSB   = 8;
    localparam int I_QK_LSB   = 12;
    localparam int I_OFIFO_RD = 16;
    localparam int I_SFP_LSB  = 17;

    localparam logic [1:0] MAC_IDLE  = 2'b00;
    localparam logic [1:0] MAC_KLOAD = 2'b01;
    localparam logic [1:0] MAC_EXEC  = 2'b10;
    localparam logic [1:0] SFP_NOP   = 2'b00;
    localparam logic [1:0] SFP_ACC   = 2'b01;

endpackage

// File: rtl/core_sequencer_psum_writeback.sv
// Delays each ofifo read issue by SFP_LAT cycles so the psum write lands when
// sfp output is valid; counts retired writes for the sequencer's exit test.
module psum_writeback
    import core_seq_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int SFP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              p_wr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [1:0]        sfp_inst_o,
    output logic [4:0]        retired_o
);

    logic [SFP_LAT-1:0]             vld_q;
    logic [SFP_LAT-1:0][ADDR_W-1:0] addr_q;
    logic [SFP_LAT:0]               vld_pipe;
    logic [SFP_LAT:0][ADDR_W-1:0]   addr_pipe;
    logic [4:0]                     retired_q;

    // Stage 0 is the live issue; the registered tail shifts it toward p_wr.
    assign vld_pipe  = {vld_q, issue_i};
    assign addr_pipe = {addr_q, addr_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            addr_q    <= '0;
            retired_q <= '0;
        end else if (clr_i) begin
            vld_q     <= '0;
            addr_q    <= '0;
            retired_q <= '0;
        end else begin
            vld_q  <= vld_pipe[SFP_LAT-1:0];
            addr_q <= addr_pipe[SFP_LAT-1:0];
            if (vld_q[SFP_LAT-1]) retired_q <= retired_q + 5'd1;
        end
    end

    assign p_wr_o     = vld_q[SFP_LAT-1];
    assign addr_o     = vld_q[SFP_LAT-1] ? addr_q[SFP_LAT-1] : '0;
    assign sfp_inst_o = vld_q[SFP_LAT-1] ? SFP_ACC : SFP_NOP;
    assign retired_o  = retired_q;

endmodule

// File: rtl/core_sequencer.sv
// Tile sequencer driving core.inst: Q/K load, kernel feed, execute, psum drain.
// Define CORE_SEQ_READBACK_EN to add a psum readback phase and rb_valid output.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int COL     = 8,
    parameter int ADDR_W  = 4,
    parameter int SFP_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        n_q,
    input  logic [3:0]        n_k,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              fifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef CORE_SEQ_READBACK_EN
    ,
    output logic              rb_valid
`endif
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  nq_q, nq_d;
    logic [3:0]  nk_q, nk_d;
    logic [4:0]  nk_ext;
    logic        legal;
    logic        issue;
    logic        wb_pwr;
    logic [ADDR_W-1:0] wb_addr;
    logic [1:0]  wb_sfp;
    logic [4:0]  wb_retired;

    assign nk_ext = {1'b0, nk_q};
    assign legal  = (n_q != 5'd0) && (n_q <= 5'd16) && (n_k != 4'd0) && (32'(n_k) <= COL);
    assign issue  = (state_q == S_DRAIN) && fifo_valid && (cnt_q < nq_q);

    psum_writeback #(.ADDR_W(ADDR_W), .SFP_LAT(SFP_LAT)) u_wb (
        .clk        (clk),
        .rst_n      (reset),
        .clr_i      (state_q != S_DRAIN),
        .issue_i    (issue),
        .addr_i     (cnt_q[ADDR_W-1:0]),
        .p_wr_o     (wb_pwr),
        .addr_o     (wb_addr),
        .sfp_inst_o (wb_sfp),
        .retired_o  (wb_retired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nq_q    <= '0;
            nk_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nq_q    <= nq_d;
            nk_q    <= nk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nq_d    = nq_q;
        nk_d    = nk_q;
        case (state_q)
            S_IDLE: if (start && legal) begin
                state_d = S_QLOAD;
                nq_d    = n_q;
                nk_d    = n_k;
                cnt_d   = '0;
            end
            S_QLOAD: if (in_valid) begin
                if (cnt_q == nq_q - 5'd1) begin
                    state_d = S_KLOAD;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
            S_KLOAD: if (in_valid) begin
                if (cnt_q == nk_ext - 5'd1) begin
                    state_d = S_KFEED;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
            // Trailing cycle (cnt == n) covers the 1-cycle SRAM read latency.
            S_KFEED: begin
                if (cnt_q == nk_ext) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
            S_EXEC: begin
                if (cnt_q == nq_q) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
            S_DRAIN: begin
                if (issue) cnt_d = cnt_q + 5'd1;
                if (wb_pwr && (wb_retired == nq_q - 5'd1)) begin
`ifdef CORE_SEQ_READBACK_EN
                    state_d = S_READBACK;
`else
                    state_d = S_DONE;
`endif
                    cnt_d   = '0;
                end
            end
`ifdef CORE_SEQ_READBACK_EN
            S_READBACK: begin
                if (cnt_q == nq_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        inst     = '0;
        in_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_IDLE: err = start && !legal;
            S_QLOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    inst[I_Q_WR]            = 1'b1;
                    inst[I_QK_LSB +: QK_W]  = cnt_q[QK_W-1:0];
                end
            end
            S_KLOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    inst[I_K_WR]            = 1'b1;
                    inst[I_QK_LSB +: QK_W]  = cnt_q[QK_W-1:0];
                end
            end
            S_KFEED: begin
                inst[I_MAC_LSB +: 2] = MAC_KLOAD;
                if (cnt_q < nk_ext) begin
                    inst[I_K_RD]            = 1'b1;
                    inst[I_QK_LSB +: QK_W]  = cnt_q[QK_W-1:0];
                end
            end
            S_EXEC: begin
                inst[I_MAC_LSB +: 2] = MAC_EXEC;
                if (cnt_q < nq_q) begin
                    inst[I_Q_RD]            = 1'b1;
                    inst[I_QK_LSB +: QK_W]  = cnt_q[QK_W-1:0];
                end
            end
            S_DRAIN: begin
                inst[I_OFIFO_RD]          = issue;
                inst[I_P_WR]              = wb_pwr;
                inst[I_PM_LSB +: ADDR_W]  = wb_addr;
                inst[I_SFP_LSB +: 2]      = wb_sfp;
            end
            S_DONE: done = 1'b1;
`ifdef CORE_SEQ_READBACK_EN
            S_READBACK: begin
                if (cnt_q < nq_q) begin
                    inst[I_P_RD]             = 1'b1;
                    inst[I_PM_LSB +: ADDR_W] = cnt_q[ADDR_W-1:0];
                end else done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);

`ifdef CORE_SEQ_READBACK_EN
    logic rb_valid_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rb_valid_q <= 1'b0;
        else        rb_valid_q <= inst[I_P_RD];
    end
    assign rb_valid = rb_valid_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a per-cycle vector table for a short tile
// and error starts, plus hand-written sequences for full tiles, drain gaps and reset.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  n_q;
    logic [3:0]  n_k;
    logic        in_valid;
    logic        in_ready;
    logic        fifo_valid;
    logic [18:0] inst;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    core_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_q        (n_q),
        .n_k        (n_k),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_valid (fifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic        start;
        logic [4:0]  nq;
        logic [3:0]  nk;
        logic        iv;
        logic        fv;
        logic [18:0] inst;
        logic        rdy;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full tile with in_valid held high; fpat bit c is fifo_valid in drain cycle c.
    task automatic run_tile(input int nq, input int nk, input logic [63:0] fpat);
        int issued, retired, paddr, c;
        logic pw, rd, fin;
        logic [31:0] exp;
        start = 1'b1; n_q = 5'(nq); n_k = 4'(nk); in_valid = 1'b1;
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd0);
        chk("start_err", 32'(err), 32'd0);
        tick();
        start = 1'b0;
        for (int i = 0; i < nq; i++) begin
            @(negedge clk);
            chk("qload", 32'(inst), 32'h10 | (i << 12));
            chk("qload_rdy", 32'(in_ready), 32'd1);
            tick();
        end
        for (int i = 0; i < nk; i++) begin
            @(negedge clk);
            chk("kload", 32'(inst), 32'h4 | (i << 12));
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i <= nk; i++) begin
            @(negedge clk);
            chk("kfeed", 32'(inst), (i < nk) ? (32'h48 | (i << 12)) : 32'h40);
            tick();
        end
        for (int i = 0; i <= nq; i++) begin
            @(negedge clk);
            chk("exec", 32'(inst), (i < nq) ? (32'hA0 | (i << 12)) : 32'h80);
            chk("exec_busy", 32'(busy), 32'd1);
            tick();
        end
        issued = 0; retired = 0; paddr = 0; pw = 1'b0; fin = 1'b0; c = 0;
        while (!fin && c < 200) begin
            fifo_valid = fpat[c % 64];
            rd  = fifo_valid && (issued < nq);
            exp = (rd ? 32'h10000 : 32'h0) | (pw ? (32'h20001 | (paddr << 8)) : 32'h0);
            @(negedge clk);
            chk("drain", 32'(inst), exp);
            if (pw) begin
                retired++;
                if (retired == nq) fin = 1'b1;
            end
            pw = rd;
            if (rd) begin
                paddr = issued;
                issued++;
            end
            tick();
            c++;
        end
        fifo_valid = 1'b0;
        if (!fin) begin
            checks++;
            $display("FAIL drain_timeout: retired %0d want %0d", retired, nq);
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_inst", 32'(inst), 32'd0);
        tick();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        tick();
    endtask

    initial begin
        // start nq nk iv fv inst rdy busy done err
        tbl[0]  = '{1'b1, 5'd0, 4'd1, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 5'd2, 4'd9, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd2, 4'd1, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd2, 4'd1, 1'b1, 1'b0, 19'h00010, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 5'd0, 4'd1, 1'b0, 1'b0, 19'h00000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd2, 4'd1, 1'b1, 1'b0, 19'h01010, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b0, 19'h00000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd2, 4'd1, 1'b1, 1'b0, 19'h00004, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b0, 19'h00048, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b0, 19'h00040, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b0, 19'h000A0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b0, 19'h010A0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b0, 19'h00080, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b1, 19'h10000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b0, 19'h20001, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b1, 19'h10000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b1, 19'h20101, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 5'd2, 4'd1, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b0; start = 1'b0; n_q = '0; n_k = '0; in_valid = 1'b0; fifo_valid = 1'b0;
        #12;
        chk("rst_inst", 32'(inst), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick();

        // Error starts, in_valid gaps in load, ignored start, drain with gap.
        for (int i = 0; i < 20; i++) begin
            start = tbl[i].start; n_q = tbl[i].nq; n_k = tbl[i].nk;
            in_valid = tbl[i].iv; fifo_valid = tbl[i].fv;
            @(negedge clk);
            chk($sformatf("vec%0d_inst", i), 32'(inst), 32'(tbl[i].inst));
            chk($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
            tick();
        end
        start = 1'b0; in_valid = 1'b0; fifo_valid = 1'b0;

        run_tile(4, 8, {64{1'b1}});
        run_tile(16, 1, {64{1'b1}});
        run_tile(4, 2, 64'hFFFF_FFFF_FFFF_FFF1);

        // Asynchronous abort in EXEC, then a fresh tile.
        start = 1'b1; n_q = 5'd3; n_k = 4'd1; in_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("pre_rst_exec", 32'(inst), 32'hA0);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async_rst_inst", 32'(inst), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_inst", 32'(inst), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        tick();
        run_tile(1, 1, {64{1'b1}});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
